// File: rtl/font_cell_sched_pkg.sv
// Shared geometry constants and FSM encoding for the font cell scheduler.
package font_cell_sched_pkg;

    localparam int unsigned C_COLS   = 16;
    localparam int unsigned C_ROWS   = 12;
    localparam int unsigned C_CELL_W = 5;
    localparam int unsigned C_CELLS  = C_COLS * C_ROWS;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/font_cell_rr_arb.sv
// Two-way round-robin arbiter; grants are combinational from the requests.
module font_cell_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr_q = 0 favours requester A (bit 0)
    logic ptr_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (gnt[0]) begin
            ptr_q <= 1'b1;
        end else if (gnt[1]) begin
            ptr_q <= 1'b0;
        end
    end

endmodule

// File: rtl/font_cell_sched.sv
// Character cell scheduler: arbitrated writes into a shadow array, frame-synchronous
// commit of the shadow into the display array, and a sequential clear.
module font_cell_sched
    import font_cell_sched_pkg::C_CELL_W;
    import font_cell_sched_pkg::state_e;
    import font_cell_sched_pkg::IDLE;
    import font_cell_sched_pkg::CLEAR;
#(
    parameter logic [8:0]  C_VLOAD = 9'd0,
    parameter int unsigned C_CELLS = font_cell_sched_pkg::C_CELLS
) (
    input  logic                          CK_i,
    input  logic                          RST_i,
    input  logic                          PX_CK_EE_i,
    input  logic [8:0]                    VCTRs_i,
    input  logic                          A_VLD_i,
    output logic                          A_RDY_o,
    input  logic [7:0]                    A_IDXs_i,
    input  logic [4:0]                    A_CODEs_i,
    input  logic                          B_VLD_i,
    output logic                          B_RDY_o,
    input  logic [7:0]                    B_IDXs_i,
    input  logic [4:0]                    B_CODEs_i,
    input  logic                          CLR_i,
    output logic [C_CELLS*C_CELL_W-1:0]   DATss_o,
    output logic                          LOAD_o,
    output logic                          BUSY_o,
    output logic                          ERR_o
);

    localparam int unsigned AW = $clog2(C_CELLS);
    localparam logic [AW-1:0] LAST = AW'(C_CELLS - 1);

    state_e          state_q;
    logic [AW-1:0]   cnt_q;
    logic            pend_q;
    logic            load_q;
    logic            err_q;
    logic [8:0]      vprev_q;

    logic [C_CELL_W-1:0] shadow_q [C_CELLS];
    logic [C_CELL_W-1:0] disp_q   [C_CELLS];

    logic            idle;
    logic            arb_en;
    logic [1:0]      gnt;
    logic            wr_en;
    logic            wr_ok;
    logic [7:0]      wr_idx;
    logic [4:0]      wr_code;
    logic            commit_evt;
    logic            do_commit;

    assign idle   = (state_q == IDLE);
    assign arb_en = idle && !RST_i;

    font_cell_rr_arb u_arb (
        .clk (CK_i),
        .rst (RST_i),
        .en  (arb_en),
        .req ({B_VLD_i, A_VLD_i}),
        .gnt (gnt)
    );

    assign A_RDY_o = gnt[0];
    assign B_RDY_o = gnt[1];

    // A grant only exists while the matching VLD is high, so a grant is a handshake.
    assign wr_en   = |gnt;
    assign wr_idx  = gnt[1] ? B_IDXs_i  : A_IDXs_i;
    assign wr_code = gnt[1] ? B_CODEs_i : A_CODEs_i;
    assign wr_ok   = 32'(wr_idx) < C_CELLS;

    // One event per frame: the line counter must have just arrived at C_VLOAD.
    assign commit_evt = PX_CK_EE_i && (VCTRs_i == C_VLOAD) && (VCTRs_i != vprev_q);
    assign do_commit  = idle && (commit_evt || pend_q);

    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            vprev_q <= '0;
        end else begin
            load_q <= do_commit;
            if (PX_CK_EE_i) begin
                vprev_q <= VCTRs_i;
            end
            if (wr_en && !wr_ok) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    pend_q <= 1'b0;
                    if (CLR_i) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end
                end
                CLEAR: begin
                    if (commit_evt) begin
                        pend_q <= 1'b1;
                    end
                    if (cnt_q == LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Display copies the pre-edge shadow, so a same-cycle write misses this commit.
    always_ff @(posedge CK_i) begin
        if (RST_i) begin
            for (int i = 0; i < C_CELLS; i++) begin
                shadow_q[i] <= '0;
                disp_q[i]   <= '0;
            end
        end else begin
            if (do_commit) begin
                for (int i = 0; i < C_CELLS; i++) begin
                    disp_q[i] <= shadow_q[i];
                end
            end
            if (idle) begin
                if (wr_en && wr_ok) begin
                    shadow_q[wr_idx[AW-1:0]] <= wr_code;
                end
            end else begin
                shadow_q[cnt_q] <= '0;
            end
        end
    end

    always_comb begin
        DATss_o = '0;
        for (int i = 0; i < C_CELLS; i++) begin
            DATss_o[i*C_CELL_W +: C_CELL_W] = disp_q[i];
        end
    end

    assign LOAD_o = load_q;
    assign BUSY_o = (state_q == CLEAR);
    assign ERR_o  = err_q;

endmodule

// File: tb/tb_font_cell_sched.sv
// Randomised and directed bench for font_cell_sched against a transaction-level model.
module tb_font_cell_sched;

    localparam int NC = 192;

    logic         clk = 1'b0;
    logic         rst;
    logic         px;
    logic [8:0]   vctr;
    logic         a_vld, b_vld, a_rdy, b_rdy;
    logic [7:0]   a_idx, b_idx;
    logic [4:0]   a_code, b_code;
    logic         clr;
    logic [959:0] dat;
    logic         load, busy, err;

    font_cell_sched dut (
        .CK_i       (clk),
        .RST_i      (rst),
        .PX_CK_EE_i (px),
        .VCTRs_i    (vctr),
        .A_VLD_i    (a_vld),
        .A_RDY_o    (a_rdy),
        .A_IDXs_i   (a_idx),
        .A_CODEs_i  (a_code),
        .B_VLD_i    (b_vld),
        .B_RDY_o    (b_rdy),
        .B_IDXs_i   (b_idx),
        .B_CODEs_i  (b_code),
        .CLR_i      (clr),
        .DATss_o    (dat),
        .LOAD_o     (load),
        .BUSY_o     (busy),
        .ERR_o      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [4:0] m_sh   [NC];
    logic [4:0] m_disp [NC];
    bit         m_err, m_pend, m_last_b;
    int         m_clear_left;
    logic [8:0] m_prev;
    bit         exp_ga, exp_gb, obs_a, obs_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_disp();
        for (int k = 0; k < NC; k++) begin
            check($sformatf("dat[%0d]", k), 32'(dat[k*5 +: 5]), 32'(m_disp[k]));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_sh[k]   = '0;
            m_disp[k] = '0;
        end
        m_err = 0; m_pend = 0; m_last_b = 1; m_clear_left = 0; m_prev = '0;
    endtask

    task automatic model_write(input logic [7:0] idx, input logic [4:0] code);
        if (int'(idx) < NC) m_sh[idx] = code;
        else m_err = 1;
    endtask

    task automatic do_reset(input int n);
        rst = 1; px = 0; vctr = '0; clr = 0;
        a_vld = 0; b_vld = 0; a_idx = '0; b_idx = '0; a_code = '0; b_code = '0;
        repeat (n) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    // One clock: drive, check grants mid-cycle, advance model at the edge, check outputs.
    task automatic run_cycle(input logic va, input logic [7:0] ia, input logic [4:0] ca,
                             input logic vb, input logic [7:0] ib, input logic [4:0] cb,
                             input logic c, input logic p, input logic [8:0] vc);
        bit in_clear, evt, cmt;
        a_vld = va; a_idx = ia; a_code = ca;
        b_vld = vb; b_idx = ib; b_code = cb;
        clr = c; px = p; vctr = vc;
        in_clear = (m_clear_left != 0);
        evt = p && (vc == 9'd0) && (vc != m_prev);
        exp_ga = 0; exp_gb = 0;
        if (!in_clear) begin
            exp_ga = va && (!vb || m_last_b);
            exp_gb = vb && !exp_ga;
        end
        @(negedge clk);
        obs_a = a_rdy; obs_b = b_rdy;
        check("a_rdy", 32'(a_rdy), 32'(exp_ga));
        check("b_rdy", 32'(b_rdy), 32'(exp_gb));
        @(posedge clk);
        #1;
        cmt = 0;
        if (!in_clear) begin
            cmt = evt || m_pend;
            m_pend = 0;
            if (cmt) m_disp = m_sh;
            if (exp_ga) begin m_last_b = 0; model_write(ia, ca); end
            if (exp_gb) begin m_last_b = 1; model_write(ib, cb); end
            if (c) m_clear_left = NC;
        end else begin
            if (evt) m_pend = 1;
            m_clear_left--;
            if (m_clear_left == 0) begin
                for (int k = 0; k < NC; k++) m_sh[k] = '0;
            end
        end
        if (p) m_prev = vc;
        check("load", 32'(load), 32'(cmt));
        check("busy", 32'(busy), 32'(m_clear_left != 0));
        check("err", 32'(err), 32'(m_err));
        if (cmt) check_disp();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Line counter steps 1 -> 0 with pixel enable; the second cycle is the commit event.
    task automatic commit(input logic va, input logic [7:0] ia, input logic [4:0] ca);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 1, 9'd1);
        run_cycle(va, ia, ca, 0, 0, 0, 0, 1, 9'd0);
    endtask

    initial begin
        int   cnt, fall_at, load_at;
        bit   a_req, b_req, c;
        logic [7:0] ai, bi;
        logic [4:0] ac, bc;

        // Reset state
        do_reset(3);
        check("rst_load", 32'(load), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_dat_lo", dat[31:0], 0);
        check_disp();
        idle_cycles(2);

        // Single write then commit
        run_cycle(1, 8'd17, 5'h1A, 0, 0, 0, 0, 0, 0);
        idle_cycles(2);
        commit(0, 0, 0);
        check("dat17", 32'(dat[89:85]), 32'h1A);

        // Round-robin from reset: A,B,A,B
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            run_cycle(1, 8'(i), 5'(i + 1), 1, 8'(100 + i), 5'(i + 8), 0, 0, 0);
            check("rr_a", 32'(obs_a), 32'((i % 2) == 0));
            check("rr_b", 32'(obs_b), 32'((i % 2) == 1));
            check("rr_both", 32'(obs_a & obs_b), 0);
        end
        idle_cycles(2);
        commit(0, 0, 0);

        // Out-of-range index from B
        run_cycle(0, 0, 0, 1, 8'd200, 5'h15, 0, 0, 0);
        check("err_set", 32'(err), 1);
        idle_cycles(2);
        commit(0, 0, 0);

        // Fill everything, then clear
        for (int i = 0; i < NC; i++) run_cycle(1, 8'(i), 5'h1F, 0, 0, 0, 0, 0, 0);
        idle_cycles(1);
        commit(0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        cnt = busy ? 1 : 0;
        for (int i = 0; i < 300 && busy; i++) begin
            run_cycle(1, 8'd3, 5'h1F, 0, 0, 0, 1, 0, 0);
            if (busy) cnt++;
        end
        check("busy_len", 32'(cnt), 32'(NC));
        idle_cycles(2);
        commit(0, 0, 0);

        // Commit event during CLEAR is deferred
        run_cycle(1, 8'd9, 5'h0C, 0, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 1, 8'd150, 5'h11, 0, 0, 0);
        idle_cycles(1);
        commit(0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle_cycles(50);
        commit(0, 0, 0);
        fall_at = -1; load_at = -1;
        for (int i = 0; i < 300 && load_at < 0; i++) begin
            run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (!busy && fall_at < 0) fall_at = i;
            if (load) load_at = i;
        end
        check("defer_load", 32'(load_at), 32'(fall_at + 1));
        check("defer_cell9", 32'(dat[49:45]), 0);

        // Write in the commit cycle waits one frame
        run_cycle(1, 8'd0, 5'h07, 0, 0, 0, 0, 0, 0);
        idle_cycles(1);
        commit(0, 0, 0);
        commit(1, 8'd0, 5'h13);
        check("same_cyc_old", 32'(dat[4:0]), 32'h07);
        idle_cycles(2);
        commit(0, 0, 0);
        check("same_cyc_new", 32'(dat[4:0]), 32'h13);

        // CLR coincident with handshake
        run_cycle(1, 8'd5, 5'h0A, 0, 0, 0, 1, 0, 0);
        idle_cycles(NC + 2);
        commit(0, 0, 0);
        check("clr_hs_cell5", 32'(dat[29:25]), 0);

        // Reset aborts CLEAR
        run_cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle_cycles(20);
        do_reset(1);
        check("abort_busy", 32'(busy), 0);
        check("abort_err", 32'(err), 0);
        check_disp();

        // Random traffic
        a_req = 0; b_req = 0; ai = '0; bi = '0; ac = '0; bc = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!a_req && $urandom_range(0, 2) == 0) begin
                a_req = 1; ai = 8'($urandom_range(0, 195)); ac = 5'($urandom);
            end
            if (!b_req && $urandom_range(0, 2) == 0) begin
                b_req = 1; bi = 8'($urandom_range(0, 191)); bc = 5'($urandom);
            end
            c = ($urandom_range(0, 249) == 0);
            run_cycle(a_req, ai, ac, b_req, bi, bc, c, 1'($urandom_range(0, 1)),
                      9'($urandom_range(0, 3)));
            if (exp_ga) a_req = 0;
            if (exp_gb) b_req = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/font_cell_sched.md
FONT_CELL_SCHED -- requirements
Module: font_cell_sched

Interface
REQ-001 SHALL have parameter C_VLOAD, default 9'd0: the VCTRs value at which the shadow buffer is committed to the display buffer.
REQ-002 SHALL have parameter C_CELLS, default 192: the number of character cells (16 columns x 12 rows).
REQ-003 CK_i  in  1  single system clock; one clock domain; reset is synchronous and active-high.
REQ-004 RST_i  in  1  synchronous active-high reset.
REQ-005 PX_CK_EE_i  in  1  pixel clock enable.
REQ-006 VCTRs_i  in  9  vertical line counter from the NTSC timing generator.
REQ-007 A_VLD_i / B_VLD_i  in  1 each  requester A/B write valid.
REQ-008 A_RDY_o / B_RDY_o  out  1 each  requester A/B write ready.
REQ-009 A_IDXs_i / B_IDXs_i  in  8 each  cell index, row*16+col.
REQ-010 A_CODEs_i / B_CODEs_i  in  5 each  cell code: {valid bit, hex nibble}.
REQ-011 CLR_i  in  1  clear request; single-cycle pulse.
REQ-012 DATss_o  out  960  display cell array; cell k occupies bits [5k+4:5k].
REQ-013 LOAD_o  out  1  one-cycle pulse when a commit occurs.
REQ-014 BUSY_o  out  1  high while in the CLEAR state.
REQ-015 ERR_o  out  1  sticky flag for an out-of-range index.

Function
REQ-016 Both display and shadow arrays SHALL hold C_CELLS 5-bit entries; writes SHALL go only to the shadow array.
REQ-017 A handshake SHALL occur on a port when VLD and RDY are both high at a CK_i rising edge.
REQ-018 The shadow entry SHALL update on the edge after acceptance (1-cycle latency).
REQ-019 In IDLE, arbitration SHALL be 2-way round-robin:
- only one RDY high per cycle;
- with a single requester, that requester gets RDY in the same cycle (combinational from VLD);
- with both requesting, the port not granted last wins;
- after reset the priority pointer favours A.
REQ-020 VLD SHALL not be required to depend on RDY; the requester holds IDX/CODE stable until its handshake.
REQ-021 An accepted write with IDX >= C_CELLS SHALL be discarded, set ERR_o, and leave the shadow unchanged; ERR_o clears only on RST_i.
REQ-022 FSM states SHALL be IDLE and CLEAR:
- IDLE->CLEAR on CLR_i=1;
- CLEAR writes 0 to shadow cells 0..C_CELLS-1, one per cycle (counter);
- CLEAR->IDLE after cell C_CELLS-1, i.e. C_CELLS cycles in CLEAR;
- CLR_i received in CLEAR is ignored.
REQ-023 In CLEAR, A_RDY_o, B_RDY_o SHALL be 0 and BUSY_o SHALL be 1.
REQ-024 Commit event SHALL be PX_CK_EE_i=1, VCTRs_i==C_VLOAD, and VCTRs_i differs from its value at the previous PX_CK_EE_i (one event per frame).
REQ-025 On a commit event in IDLE, the display array SHALL copy the whole shadow array on the next edge and LOAD_o SHALL pulse in that cycle.
REQ-026 A commit event during CLEAR SHALL set a pending flag; the commit SHALL execute on the first IDLE cycle after CLEAR ends, then the flag clears.
REQ-027 A write accepted in the same cycle as a commit SHALL not appear in that commit; it appears at the next commit.
REQ-028 CLR_i coincident with a handshake: the handshake completes and CLEAR starts next cycle, so the written cell is then zeroed.

Reset
REQ-029 RST_i=1 SHALL leave these values after the edge:
- DATss_o, shadow array, clear counter: all 0;
- LOAD_o, BUSY_o, ERR_o, RDYs, pending flag: 0;
- FSM: IDLE; round-robin pointer: favours A.
REQ-030 RST_i SHALL abort CLEAR mid-sequence and take priority over every other event.

Structure
REQ-031 A shared package SHALL hold C_COLS=16, C_ROWS=12, C_CELL_W=5, C_CELLS=192 and the state encodings IDLE/CLEAR.
REQ-032 Arbitration SHALL be in sub-module font_cell_rr_arb (2 requests in, 2 grants out, pointer update on grant).

Verification
REQ-033 Reset, then A writes idx 17 code 5'h1A; commit at VCTRs=0 -> LOAD_o pulses and DATss_o[89:85] = 5'h1A.
REQ-034 A and B held valid for 4 cycles -> grants A,B,A,B; never both RDY high in one cycle.
REQ-035 B writes idx 200 -> ERR_o = 1; shadow unchanged; DATss_o unchanged after the next commit.
REQ-036 Fill all cells with 5'h1F, then pulse CLR_i -> BUSY_o high for exactly 192 cycles; RDYs 0 throughout; after the next commit DATss_o = 0.
REQ-037 Commit event during CLEAR -> no LOAD_o until CLEAR ends; LOAD_o in the first IDLE cycle; DATss_o = all zero.
REQ-038 Write idx 0 code 5'h13 accepted in the commit cycle -> DATss_o[4:0] unchanged this frame and 5'h13 after the following commit.
